// File: rtl/osd_text_sequencer.sv
// OSD text sequencer: walks a COLS x ROWS character buffer through an external glyph ROM
// and serialises each 4x6 character cell into a 1-bit pixel stream, one video line at a time.
module osd_text_sequencer #(
    parameter int COLS = 16,
    parameter int ROWS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       line_start,
    input  logic       pix_ce,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [5:0] wr_data,
    output logic [5:0] rom_char_add,
    output logic [2:0] rom_px_line,
    input  logic [2:0] rom_q,
    output logic       osd_pixel,
    output logic       osd_active,
    output logic       busy
);
    localparam int DEPTH = COLS * ROWS;
    localparam int LINES = ROWS * 6;
    localparam int LW    = $clog2(LINES + 1);
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_PREFETCH, ST_ACTIVE} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic [2:0]    px_line_q, px_line_d;
    logic [CW-1:0] col_q, col_d;
    logic [1:0]    pix_cnt_q, pix_cnt_d;
    logic          rd_v_q, rd_v_d;
    logic          addr_v_q, addr_v_d;
    logic          rom_v_q, rom_v_d;
    logic          blank_q, blank_d;
    logic          fetch_req_q, fetch_req_d;
    logic [3:0]    glyph_q, glyph_d;
    logic          glyph_v_q, glyph_v_d;
    logic [3:0]    shift_q, shift_d;
    logic [5:0]    char_add_q, char_add_d;
    logic [2:0]    rom_line_q, rom_line_d;
    logic          pixel_q, pixel_d;
    logic          active_q, active_d;

    logic [5:0]    text_mem [DEPTH];
    logic [5:0]    text_rd_q;
    logic          rd_en;
    logic [5:0]    rd_addr;

    logic [LW-1:0] line_base;
    logic          line_ok;
    logic [3:0]    cap_val;

    // Text buffer: registered read, write-first not required so a same-address read sees old data.
    always_ff @(posedge clock) begin
        if (wr_en) text_mem[wr_addr] <= wr_data;
        if (rd_en) text_rd_q <= text_mem[rd_addr];
    end

    assign line_base = frame_start ? '0 : line_cnt_q;
    assign line_ok   = (line_base < LW'(LINES));
    assign cap_val   = blank_q ? 4'b0000 : {rom_q, 1'b0};

    always_comb begin
        state_d     = state_q;
        line_cnt_d  = line_cnt_q;
        row_d       = row_q;
        px_line_d   = px_line_q;
        col_d       = col_q;
        pix_cnt_d   = pix_cnt_q;
        rd_v_d      = 1'b0;
        addr_v_d    = rd_v_q;
        rom_v_d     = addr_v_q;
        blank_d     = blank_q;
        fetch_req_d = fetch_req_q;
        glyph_d     = glyph_q;
        glyph_v_d   = glyph_v_q;
        shift_d     = shift_q;
        char_add_d  = char_add_q;
        rom_line_d  = rom_line_q;
        pixel_d     = 1'b0;
        active_d    = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = 6'(int'(row_q) * COLS + int'(col_q) + 1);

        if (rd_v_q) begin
            char_add_d = text_rd_q;
            rom_line_d = px_line_q;
            blank_d    = (text_rd_q >= 6'd46) || (px_line_q == 3'd5);
        end
        if (frame_start) line_cnt_d = '0;

        case (state_q)
            ST_PREFETCH: begin
                if (rom_v_q) begin
                    shift_d     = cap_val;
                    col_d       = '0;
                    pix_cnt_d   = '0;
                    glyph_v_d   = 1'b0;
                    fetch_req_d = (COLS > 1);
                    state_d     = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (fetch_req_q) begin
                    rd_en       = 1'b1;
                    rd_v_d      = 1'b1;
                    fetch_req_d = 1'b0;
                end
                if (rom_v_q) begin
                    glyph_d   = cap_val;
                    glyph_v_d = 1'b1;
                end
                if (pix_ce) begin
                    pixel_d   = shift_q[3];
                    active_d  = 1'b1;
                    shift_d   = {shift_q[2:0], 1'b0};
                    pix_cnt_d = pix_cnt_q + 2'd1;
                    if (pix_cnt_q == 2'd3) begin
                        glyph_v_d = 1'b0;
                        if (col_q == CW'(COLS - 1)) begin
                            shift_d = 4'b0000;
                            state_d = ST_IDLE;
                        end else begin
                            // With pix_ce every clock the next glyph lands on this very edge.
                            shift_d     = glyph_v_q ? glyph_q : cap_val;
                            col_d       = col_q + CW'(1);
                            fetch_req_d = (int'(col_q) + 2 < COLS);
                        end
                    end
                end
            end
            default: ;
        endcase

        // A new line always wins: drop whatever is in flight and restart from column 0.
        if (line_start) begin
            line_cnt_d  = line_ok ? line_base + LW'(1) : line_base;
            addr_v_d    = 1'b0;
            rom_v_d     = 1'b0;
            glyph_v_d   = 1'b0;
            fetch_req_d = 1'b0;
            shift_d     = 4'b0000;
            col_d       = '0;
            pix_cnt_d   = '0;
            pixel_d     = 1'b0;
            active_d    = 1'b0;
            rd_v_d      = 1'b0;
            state_d     = ST_IDLE;
            if (line_ok) begin
                state_d   = ST_PREFETCH;
                row_d     = RW'(line_base / LW'(6));
                px_line_d = 3'(line_base % LW'(6));
                rd_en     = 1'b1;
                rd_addr   = 6'(int'(line_base / LW'(6)) * COLS);
                rd_v_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            line_cnt_q  <= '0;
            row_q       <= '0;
            px_line_q   <= '0;
            col_q       <= '0;
            pix_cnt_q   <= '0;
            rd_v_q      <= 1'b0;
            addr_v_q    <= 1'b0;
            rom_v_q     <= 1'b0;
            blank_q     <= 1'b0;
            fetch_req_q <= 1'b0;
            glyph_q     <= '0;
            glyph_v_q   <= 1'b0;
            shift_q     <= '0;
            char_add_q  <= '0;
            rom_line_q  <= '0;
            pixel_q     <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_cnt_q  <= line_cnt_d;
            row_q       <= row_d;
            px_line_q   <= px_line_d;
            col_q       <= col_d;
            pix_cnt_q   <= pix_cnt_d;
            rd_v_q      <= rd_v_d;
            addr_v_q    <= addr_v_d;
            rom_v_q     <= rom_v_d;
            blank_q     <= blank_d;
            fetch_req_q <= fetch_req_d;
            glyph_q     <= glyph_d;
            glyph_v_q   <= glyph_v_d;
            shift_q     <= shift_d;
            char_add_q  <= char_add_d;
            rom_line_q  <= rom_line_d;
            pixel_q     <= pixel_d;
            active_q    <= active_d;
        end
    end

    assign rom_char_add = char_add_q;
    assign rom_px_line  = rom_line_q;
    assign osd_pixel    = pixel_q;
    assign osd_active   = active_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_osd_text_sequencer.sv
// Directed + randomized bench for osd_text_sequencer: a 1-clock glyph ROM model and a
// line-level reference that rebuilds each rendered line from the text buffer contents.
module tb_osd_text_sequencer;
    localparam int COLS  = 16;
    localparam int ROWS  = 4;
    localparam int LINES = ROWS * 6;

    logic       clock = 1'b0;
    logic       reset, frame_start, line_start, pix_ce, wr_en;
    logic [5:0] wr_addr, wr_data, rom_char_add;
    logic [2:0] rom_px_line, rom_q;
    logic       osd_pixel, osd_active, busy;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [5:0] text_model [COLS*ROWS];

    always #5 clock = ~clock;

    osd_text_sequencer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clock        (clock),
        .reset        (reset),
        .frame_start  (frame_start),
        .line_start   (line_start),
        .pix_ce       (pix_ce),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rom_char_add (rom_char_add),
        .rom_px_line  (rom_px_line),
        .rom_q        (rom_q),
        .osd_pixel    (osd_pixel),
        .osd_active   (osd_active),
        .busy         (busy)
    );

    function automatic logic [2:0] rom_fn(input logic [5:0] code, input logic [2:0] line);
        return 3'((int'(code) * 5 + int'(line) * 3 + 2) ^ (int'(code) >> 3));
    endfunction

    always @(posedge clock) rom_q <= rom_fn(rom_char_add, rom_px_line);

    // Expected 64-pixel line, first emitted pixel in the MSB.
    function automatic logic [63:0] exp_line(input int n);
        logic [63:0] v = '0;
        int          row, gl;
        logic [5:0]  code;
        if (n >= LINES) return '0;
        row = n / 6;
        gl  = n % 6;
        for (int c = 0; c < COLS; c++) begin
            code = text_model[row * COLS + c];
            v = {v[59:0], (gl == 5 || code >= 6'd46) ? 4'b0000 : {rom_fn(code, 3'(gl)), 1'b0}};
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [5:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        text_model[a] = d;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    // Issue one line_start and collect every pixel flagged by osd_active until the line ends.
    task automatic render(input bit fs, input bit full_ce, input int abort_px,
                          output logic [63:0] got, output int cnt, output int lat,
                          output logic [5:0] add_k2, output logic [2:0] pxl_k2, output bit busy_seen);
        bit aborted = 0;
        got = '0; cnt = 0; lat = -1; add_k2 = '0; pxl_k2 = '0; busy_seen = 0;
        frame_start = fs; line_start = 1'b1;
        pix_ce = full_ce ? 1'b1 : 1'($urandom_range(0, 2) != 0);
        for (int k = 1; k <= 400; k++) begin
            @(negedge clock);
            frame_start = 1'b0; line_start = 1'b0;
            if (busy) busy_seen = 1;
            if (k == 2) begin add_k2 = rom_char_add; pxl_k2 = rom_px_line; end
            if (osd_active) begin
                if (lat < 0) lat = k;
                got = {got[62:0], osd_pixel};
                cnt++;
                if (cnt == abort_px) begin aborted = 1; break; end
            end
            if (k > 1 && !busy && !osd_active) break;
            pix_ce = full_ce ? 1'b1 : 1'($urandom_range(0, 2) != 0);
        end
        if (!aborted) pix_ce = 1'b0;
    endtask

    task automatic do_line(input int n, input bit fs, input bit full_ce, output logic [63:0] got);
        int cnt, lat; logic [5:0] a2; logic [2:0] p2; bit bs;
        render(fs, full_ce, 0, got, cnt, lat, a2, p2, bs);
        $display("line %0d: pixels %016h count %0d latency %0d", n, got, cnt, lat);
        check($sformatf("line%0d_pixels", n), got, exp_line(n));
        check($sformatf("line%0d_count", n), 64'(cnt), 64'(COLS * 4));
        check($sformatf("line%0d_px_line", n), 64'(p2), 64'(n % 6));
        check($sformatf("line%0d_char_add", n), 64'(a2), 64'(text_model[(n / 6) * COLS]));
        if (full_ce) check($sformatf("line%0d_latency", n), 64'(lat), 64'd5);
    endtask

    initial begin
        logic [63:0] got, e;
        int          cnt, lat;
        logic [5:0]  a2;
        logic [2:0]  p2;
        bit          bs, seen;

        reset = 1'b1; frame_start = 1'b0; line_start = 1'b0; pix_ce = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clock);
        check("rst_osd_pixel", 64'(osd_pixel), 64'd0);
        check("rst_osd_active", 64'(osd_active), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rom_char_add", 64'(rom_char_add), 64'd0);
        check("rst_rom_px_line", 64'(rom_px_line), 64'd0);
        reset = 1'b0;

        for (int a = 0; a < COLS * ROWS; a++)
            wr(6'(a), (a == 0) ? 6'd0 : (a == 3) ? 6'd50 : 6'($urandom_range(0, 63)));

        frame_start = 1'b1; @(negedge clock); frame_start = 1'b0;
        for (int n = 0; n < LINES; n++) begin
            do_line(n, 1'b0, (n < 6) || (n % 3 == 0), got);
            if (n == 0) begin
                check("line0_col0", 64'(got[63:60]), 64'b0100);
                check("line0_col3_blank", 64'(got[51:48]), 64'd0);
            end
            if (n == 5) check("line5_all_blank", got, 64'd0);
        end

        render(1'b0, 1'b1, 0, got, cnt, lat, a2, p2, bs);
        $display("line 24 (beyond window): count %0d busy_seen %0d", cnt, bs);
        check("line24_busy", 64'(bs), 64'd0);
        check("line24_count", 64'(cnt), 64'd0);

        do_line(0, 1'b1, 1'b1, got);
        do_line(1, 1'b0, 1'b0, got);

        render(1'b0, 1'b1, 32, got, cnt, lat, a2, p2, bs);
        e = exp_line(2);
        $display("line 2 aborted after %0d pixels: %08h", cnt, got[31:0]);
        check("abort_partial", 64'(got[31:0]), 64'(e[63:32]));
        do_line(3, 1'b0, 1'b1, got);
        do_line(4, 1'b0, 1'b1, got);

        for (int i = 0; i < 6; i++) wr(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        do_line(5, 1'b0, 1'b0, got);
        do_line(6, 1'b0, 1'b0, got);
        do_line(7, 1'b0, 1'b1, got);

        render(1'b0, 1'b1, 10, got, cnt, lat, a2, p2, bs);
        reset = 1'b1; pix_ce = 1'b1;
        @(negedge clock);
        $display("reset mid-line: osd_active %0b osd_pixel %0b busy %0b", osd_active, osd_pixel, busy);
        check("midrst_osd_active", 64'(osd_active), 64'd0);
        check("midrst_osd_pixel", 64'(osd_pixel), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_rom_char_add", 64'(rom_char_add), 64'd0);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (osd_active || busy) seen = 1;
        end
        pix_ce = 1'b0;
        check("post_rst_quiet", 64'(seen), 64'd0);
        do_line(0, 1'b0, 1'b1, got);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
